ex_stage: RTL
=============

# ex_stage

Execute stage of the pipelined microcontroller, on the consuming side of the ID→EX pipeline register. It:
- takes the registered ID→EX bundle (`wr_enx1`, `ALUsrc1x1`/`ALUsrc2x1`, `ALUopx1`, `immx1`, `dat1x1`/`dat2x1`, `dstx1`);
- selects operands and executes the ALU operation;
- writes the EX→WB register.

It also returns a stall to the ID side while an iterative multiply is in progress. `resx2` is the forwarding source for the next instruction.

## Interface
- `DATA_W`, 16, width of `t_data`
- `RF_AW`, 3, width of `t_RFadrs` (8 GPRs)
- `clock`  in  1  sole clock, rising edge
- `reset_n`  in  1  reset, synchronous, active-low
- `wr_enx1`  in  1  instruction valid and writes back; 0 = bubble
- `ALUsrc1x1`, `ALUsrc2x1`  in  `t_ALUsrc_ctrl`  operand source: `takeGPR`, `takeImm`, `takeFwd`
- `ALUopx1`  in  `t_opcode`  `LD`, `ADD`, `SUB`, `AND`, `OR`, `XOR`, `SHL`, `SHR`, `MUL`
- `immx1`  in  `DATA_W`  immediate
- `dat1x1`, `dat2x1`  in  `DATA_W`  GPR read data
- `dstx1`  in  `RF_AW`  destination register
- `stall`  out  1  ID→EX register and earlier stages must hold
- `wr_enx2`  out  1  EX→WB write enable
- `dstx2`  out  `RF_AW`  EX→WB destination
- `resx2`  out  `DATA_W`  EX→WB result, also forwarding source

## Operation

**Operand select** (per operand n = 1, 2):
- `takeGPR` → `datnx1`
- `takeImm` → `immx1`
- `takeFwd` → current `resx2`

**ALU** (modulo 2^DATA_W):
- `LD` → src2
- `ADD` → src1+src2
- `SUB` → src1−src2
- `AND` / `OR` / `XOR` → bitwise
- `SHL` / `SHR` → logical shift of src1 by src2[log2(DATA_W)−1:0]
- `MUL` → low DATA_W bits of src1×src2

**Single-cycle ops:** at the clock edge, `resx2` ← result, `dstx2` ← `dstx1`, `wr_enx2` ← 1.

**Bubble** (`wr_enx1`=0): `wr_enx2` ← 0; `resx2` and `dstx2` hold.

**MUL FSM**, states IDLE and BUSY, with a 4-bit counter `cnt`:
- **IDLE, `wr_enx1`=1, `ALUopx1`=`MUL`:**
  - `stall`=1 combinationally.
  - At the edge: latch multiplicand = src1 and multiplier = src2 (`takeFwd` resolves to `resx2` at this point), clear the accumulator, `cnt`←0, `wr_enx2`←0, go to BUSY.
- **BUSY, each edge:**
  - If multiplier bit `cnt` is 1, add (multiplicand << `cnt`) into the accumulator.
  - `cnt`++.
  - `wr_enx2` stays 0.
- **BUSY:** `stall` = (`cnt` ≠ DATA_W−1).
- **BUSY, edge at `cnt`=DATA_W−1:**
  - `resx2` ← final accumulator; `dstx2` ← latched dst; `wr_enx2` ← 1; go to IDLE.
  - `stall` is already low, so ID→EX advances on this same edge.
- **Inputs while BUSY:** ignored. They are held upstream and show the same `MUL`.

**Reset** (`reset_n`=0 at an edge):
- `wr_enx2`=0, `resx2`=0, `dstx2`=0, state IDLE, `cnt`=0, accumulator 0.
- `stall` is forced to 0 while `reset_n`=0.
- Reset mid-MUL aborts it; no writeback is produced.

## Timing
- Single-cycle op: result in `resx2` one edge after it is presented; a back-to-back `takeFwd` sees it.
- MUL: result is visible DATA_W+1 edges after it is first presented (17 for DATA_W=16).
  - `stall` is high for the first DATA_W of those cycles.
  - `wr_enx2` is 0 for DATA_W edges, then 1 for exactly one cycle.
- Back-to-back MULs: the second one enters IDLE-capture on the cycle after the first completes.
- `stall` depends only on state, `cnt`, `wr_enx1`, `ALUopx1`, and `reset_n`. There is no path from data inputs.

## Configuration
- `EX_MUL_EN` defined: FSM and multiplier are compiled in as described above.
- `EX_MUL_EN` undefined:
  - No FSM, counter, or accumulator; `stall` is tied to 0.
  - `MUL` is treated as a bubble: `wr_enx2`←0, `resx2` and `dstx2` hold.

## Test plan
- **Reset:** after reset, `wr_enx2`=0, `resx2`=0, `dstx2`=0, `stall`=0.
- **ADD, `takeGPR`:** `dat1x1`=5, `dat2x1`=7, `dstx1`=3 → next edge `resx2`=12, `dstx2`=3, `wr_enx2`=1.
- **Forward chain:**
  - `LD` `takeImm` `immx1`=0xFFFF, then `ADD` with src1=`takeFwd`, src2 `takeImm`=1.
  - → `resx2`=0xFFFF, then 0x0000 (wrap).
  - Then `SHL` with src1 `takeImm`=1, src2 `takeImm`=15 → 0x8000.
- **Bubble:** `wr_enx1`=0 after a valid op → `wr_enx2`=0; `resx2` and `dstx2` unchanged.
- **MUL, `EX_MUL_EN` defined:**
  - 300×200, `dstx1`=5 → `stall` high for 16 cycles, `wr_enx2`=0 for 16 edges.
  - On the 17th edge: `resx2`=0xEA60, `dstx2`=5, `wr_enx2`=1.
  - A following `ADD` `takeFwd`+`takeImm` 1 → 0xEA61.
- **Reset mid-MUL:** `reset_n`=0 at BUSY `cnt`=8 → state IDLE, `stall`=0, `wr_enx2` never pulses for that MUL.
  - Without `EX_MUL_EN`: `MUL` → `stall` stays 0, `wr_enx2`=0.

Source files
------------

// File: rtl/ex_stage_if.sv
// ex_stage_if: ID->EX pipeline bundle into the execute stage, plus the
// EX->WB register outputs and the stall returned to the ID side.
// Operand-source encoding: 0 = takeGPR, 1 = takeImm, 2 = takeFwd.
// Opcode encoding: LD=0 ADD=1 SUB=2 AND=3 OR=4 XOR=5 SHL=6 SHR=7 MUL=8.
interface ex_stage_if #(
  parameter int DATA_W = 16,
  parameter int RF_AW  = 3
);
  logic              wr_enx1;
  logic [1:0]        ALUsrc1x1;
  logic [1:0]        ALUsrc2x1;
  logic [3:0]        ALUopx1;
  logic [DATA_W-1:0] immx1;
  logic [DATA_W-1:0] dat1x1;
  logic [DATA_W-1:0] dat2x1;
  logic [RF_AW-1:0]  dstx1;
  logic              stall;
  logic              wr_enx2;
  logic [RF_AW-1:0]  dstx2;
  logic [DATA_W-1:0] resx2;

  // ID side: drives the bundle, honours stall, observes writeback
  modport master (
    output wr_enx1, ALUsrc1x1, ALUsrc2x1, ALUopx1, immx1, dat1x1, dat2x1, dstx1,
    input  stall, wr_enx2, dstx2, resx2
  );

  // Execute stage
  modport slave (
    input  wr_enx1, ALUsrc1x1, ALUsrc2x1, ALUopx1, immx1, dat1x1, dat2x1, dstx1,
    output stall, wr_enx2, dstx2, resx2
  );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the pipelined microcontroller. Selects the
// operands, runs the ALU and writes the EX->WB register. resx2 doubles as
// the forwarding source for the following instruction.
//
// Build option EX_MUL_EN: when defined, MUL runs as an iterative
// shift-and-add over DATA_W cycles and stalls the ID side meanwhile. When
// undefined, no multiplier exists, stall is tied low and MUL is a bubble.
//
// MUL sequencer (EX_MUL_EN only):
//   state | meaning
//   IDLE  | single-cycle ops execute; a valid MUL latches operands -> BUSY
//   BUSY  | one multiplier bit per cycle; at cnt = DATA_W-1 write back -> IDLE
module ex_stage #(
  parameter int DATA_W = 16,
  parameter int RF_AW  = 3
) (
  input logic         clock,
  input logic         reset_n,
  ex_stage_if.slave   bus
);

  localparam int SH_W = $clog2(DATA_W);

  localparam logic [1:0] SRC_GPR = 2'd0;
  localparam logic [1:0] SRC_IMM = 2'd1;
  localparam logic [1:0] SRC_FWD = 2'd2;

  localparam logic [3:0] OP_LD  = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;

  logic              wr_en_q;
  logic [RF_AW-1:0]  dst_q;
  logic [DATA_W-1:0] res_q;

  logic [DATA_W-1:0] src1;
  logic [DATA_W-1:0] src2;
  logic [DATA_W-1:0] alu_res;
  logic              is_mul;

  assign bus.wr_enx2 = wr_en_q;
  assign bus.dstx2   = dst_q;
  assign bus.resx2   = res_q;
  assign is_mul      = (bus.ALUopx1 == OP_MUL);

  // Operand 1 select; forwarding reads the current EX->WB result
  always_comb begin
    src1 = bus.dat1x1;
    case (bus.ALUsrc1x1)
      SRC_GPR: src1 = bus.dat1x1;
      SRC_IMM: src1 = bus.immx1;
      SRC_FWD: src1 = res_q;
      default: src1 = bus.dat1x1;
    endcase
  end

  // Operand 2 select
  always_comb begin
    src2 = bus.dat2x1;
    case (bus.ALUsrc2x1)
      SRC_GPR: src2 = bus.dat2x1;
      SRC_IMM: src2 = bus.immx1;
      SRC_FWD: src2 = res_q;
      default: src2 = bus.dat2x1;
    endcase
  end

  // Single-cycle ALU; MUL is handled by the sequencer, not here
  always_comb begin
    alu_res = '0;
    case (bus.ALUopx1)
      OP_LD:   alu_res = src2;
      OP_ADD:  alu_res = src1 + src2;
      OP_SUB:  alu_res = src1 - src2;
      OP_AND:  alu_res = src1 & src2;
      OP_OR:   alu_res = src1 | src2;
      OP_XOR:  alu_res = src1 ^ src2;
      OP_SHL:  alu_res = src1 << src2[SH_W-1:0];
      OP_SHR:  alu_res = src1 >> src2[SH_W-1:0];
      default: alu_res = '0;
    endcase
  end

`ifdef EX_MUL_EN

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  logic [0:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [DATA_W-1:0] acc;
  logic [RF_AW-1:0]  mul_dst;
  logic [DATA_W-1:0] acc_next;

  // Partial-product add for the multiplier bit selected by cnt
  always_comb begin
    acc_next = acc;
    if (mplier[cnt]) acc_next = acc + (mcand << cnt);
  end

  // Stall is a function of control only, never of operand data
  always_comb begin
    bus.stall = 1'b0;
    if (reset_n) begin
      if (state == ST_BUSY)   bus.stall = (cnt != CNT_LAST);
      else                    bus.stall = bus.wr_enx1 && is_mul;
    end
  end

  // EX->WB register and MUL sequencer
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_en_q <= 1'b0;
      dst_q   <= '0;
      res_q   <= '0;
      state   <= ST_IDLE;
      cnt     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      mul_dst <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.wr_enx1 && is_mul) begin
            mcand   <= src1;
            mplier  <= src2;
            mul_dst <= bus.dstx1;
            acc     <= '0;
            cnt     <= '0;
            wr_en_q <= 1'b0;
            state   <= ST_BUSY;
          end else if (bus.wr_enx1) begin
            res_q   <= alu_res;
            dst_q   <= bus.dstx1;
            wr_en_q <= 1'b1;
          end else begin
            wr_en_q <= 1'b0;
          end
        end
        ST_BUSY: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            res_q   <= acc_next;
            dst_q   <= mul_dst;
            wr_en_q <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            wr_en_q <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          wr_en_q <= 1'b0;
        end
      endcase
    end
  end

`else

  assign bus.stall = 1'b0;

  // EX->WB register; MUL without the multiplier behaves as a bubble
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_en_q <= 1'b0;
      dst_q   <= '0;
      res_q   <= '0;
    end else if (bus.wr_enx1 && !is_mul) begin
      res_q   <= alu_res;
      dst_q   <= bus.dstx1;
      wr_en_q <= 1'b1;
    end else begin
      wr_en_q <= 1'b0;
    end
  end

`endif

endmodule
